// File: rtl/fp32_pkg.sv
// Shared binary32 field definitions, constants and classification helpers
// for the single-precision adder datapath.
package fp32_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
  } fp_t;

  // Subnormals count as zero: the adder flushes them.
  function automatic logic is_zero(input logic [31:0] w);
    return w[30:23] == '0;
  endfunction

  function automatic logic is_inf(input logic [31:0] w);
    return (w[30:23] == '1) && (w[22:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == '1) && (w[22:0] != '0);
  endfunction

  function automatic fp_t unpack(input logic [31:0] w);
    fp_t f;
    f.sign = w[31];
    f.exp  = w[30:23];
    f.sig  = is_zero(w) ? '0 : {1'b1, w[22:0]};
    return f;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// 25-bit leading-zero counter; an all-zero input reports 25.
module fp_lzc (
  input  logic [24:0] i_val,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = 5'd25;
    // Scanning up from the LSB, the highest set bit writes last and wins.
    for (int i = 0; i < 25; i++)
      if (i_val[i]) o_cnt = 5'(24 - i);
  end
endmodule

// File: rtl/floating_point_adder.sv
// Single-cycle binary32 adder, round-to-nearest-even, flush-to-zero,
// with an enable-gated output register.
module floating_point_adder
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        enable,
  output logic [31:0] Out
);
  fp_t         w_a, w_b, w_x, w_y;
  logic        w_a_ge, w_sub, w_carry, w_inc;
  logic [7:0]  w_d;
  logic [49:0] w_wide;
  logic [26:0] w_x_al, w_y_al, w_norm;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [24:0] w_rnd;
  logic [22:0] w_frac;
  logic signed [9:0] w_exp_n, w_exp_r;
  logic [31:0] w_res;
  logic [31:0] r_out;

  assign w_a    = unpack(A);
  assign w_b    = unpack(B);
  assign w_a_ge = {w_a.exp, w_a.sig} >= {w_b.exp, w_b.sig};
  assign w_x    = w_a_ge ? w_a : w_b;
  assign w_y    = w_a_ge ? w_b : w_a;

  // Align Y into a 27-bit {sig, G, R, S} frame; far shifts keep only sticky.
  assign w_d    = w_x.exp - w_y.exp;
  assign w_wide = {w_y.sig, 26'b0} >> w_d;
  assign w_y_al = (w_d >= 8'd27) ? {26'b0, |w_y.sig}
                                 : {w_wide[49:24], |w_wide[23:0]};
  assign w_x_al = {w_x.sig, 3'b0};

  assign w_sub   = w_x.sign ^ w_y.sign;
  assign w_sum   = w_sub ? ({1'b0, w_x_al} - {1'b0, w_y_al})
                         : ({1'b0, w_x_al} + {1'b0, w_y_al});
  assign w_carry = w_sum[27];

  fp_lzc u_lzc (.i_val(w_sum[26:2]), .o_cnt(w_lz));

  assign w_norm  = w_carry ? {w_sum[27:2], |w_sum[1:0]} : (w_sum[26:0] << w_lz);
  assign w_exp_n = w_carry ? ($signed({2'b0, w_x.exp}) + 10'sd1)
                           : ($signed({2'b0, w_x.exp}) - $signed({5'b0, w_lz}));

  // Round to nearest-even on {mant, G, R, S}.
  assign w_inc   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_rnd   = {1'b0, w_norm[26:3]} + {24'b0, w_inc};
  assign w_frac  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
  assign w_exp_r = w_exp_n + $signed({9'b0, w_rnd[24]});

  always_comb begin
    w_res = {w_x.sign, w_exp_r[7:0], w_frac};
    if (is_nan(A) || is_nan(B))
      w_res = QNAN;
    else if (is_inf(A) && is_inf(B) && (A[31] != B[31]))
      w_res = QNAN;
    else if (is_inf(A))
      w_res = A;
    else if (is_inf(B))
      w_res = B;
    else if (w_sum == '0)
      w_res = {w_x.sign & w_y.sign, 31'b0};
    else if (w_exp_r >= 10'sd255)
      w_res = {w_x.sign, 8'hFF, 23'b0};
    else if (w_exp_r <= 10'sd0)
      w_res = {w_x.sign, 31'b0};
  end

  always_ff @(posedge clk) begin
    if (rst)         r_out <= '0;
    else if (enable) r_out <= w_res;
  end

  assign Out = r_out;
endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder with hand-computed results.
module tb_floating_point_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        enable = 1'b0;
  logic [31:0] Out;

  int n_chk  = 0;
  int n_fail = 0;

  floating_point_adder dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .enable(enable), .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one operand pair, clock once, sample 1 time unit after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic en, input logic r);
    A = a; B = b; enable = en; rst = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] va [12];
  logic [31:0] vb [12];
  logic [31:0] vr [12];

  initial begin
    va = '{32'h41360001, 32'h426FEB85, 32'h447A2000, 32'h44097F2B,
           32'h40000000, 32'h3F800000, 32'h80000000, 32'h7F800000,
           32'h7FC00001, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000};
    vb = '{32'h40B2041B, 32'h40D00000, 32'h447569DB, 32'h40B20419,
           32'hBF800000, 32'hBF800000, 32'h80000000, 32'hFF800000,
           32'h3F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h40200000};
    vr = '{32'h41878107, 32'h4284F5C2, 32'h44F7C4EE, 32'h440AE333,
           32'h3F800000, 32'h00000000, 32'h80000000, 32'h7FC00000,
           32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h40600000};

    // Reset dominates enable even with live operands.
    step(32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
    chk("reset", Out, 32'h00000000);
    step(32'h3F800000, 32'h3F800000, 1'b1, 1'b1);

    // Directed vectors, one pair per cycle, back to back.
    for (int i = 0; i < 12; i++) begin
      step(va[i], vb[i], 1'b1, 1'b0);
      chk($sformatf("vec%0d", i), Out, vr[i]);
    end

    // Extra boundaries: subnormal flush, sticky-only far shift, underflow, -inf.
    step(32'h00000001, 32'h3F800000, 1'b1, 1'b0);
    chk("subnormal_flush", Out, 32'h3F800000);
    step(32'h3F800000, 32'h30800000, 1'b1, 1'b0);
    chk("far_shift", Out, 32'h3F800000);
    step(32'h00800000, 32'h80800001, 1'b1, 1'b0);
    chk("underflow", Out, 32'h80000000);
    step(32'hFF800000, 32'h3F800000, 1'b1, 1'b0);
    chk("neg_inf", Out, 32'hFF800000);
    step(32'hC0400000, 32'h3F800000, 1'b1, 1'b0);
    chk("neg_sub", Out, 32'hC0000000);

    // Enable hold.
    step(32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    chk("hold_load", Out, 32'h40000000);
    for (int i = 0; i < 5; i++) begin
      step($urandom, $urandom, 1'b0, 1'b0);
      chk($sformatf("hold%0d", i), Out, 32'h40000000);
    end
    step(32'h40000000, 32'h3F800000, 1'b1, 1'b0);
    chk("hold_release", Out, 32'h40400000);

    // Reset mid-stream, then results resume.
    step(32'h3F000000, 32'h3E800000, 1'b1, 1'b0);
    chk("stream_a", Out, 32'h3F400000);
    step(32'h3F800000, 32'h40200000, 1'b1, 1'b1);
    chk("stream_rst", Out, 32'h00000000);
    step(32'h3F800000, 32'h40200000, 1'b1, 1'b0);
    chk("stream_resume", Out, 32'h40600000);
    step(32'h40000000, 32'hBF800000, 1'b1, 1'b0);
    chk("stream_next", Out, 32'h3F800000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
